// File: rtl/perceptron_trainer_if.sv
// Control and result bundle between a perceptron trainer and its host.
// The host drives start/targets; the trainer drives weights and status.
interface perceptron_trainer_if #(
    parameter int N  = 33,
    parameter int EW = 5
);
    logic           start_in;
    logic [3:0]     targets_in;
    logic [N-1:0]   w1_out;
    logic [N-1:0]   w2_out;
    logic [N-1:0]   wb_out;
    logic [EW-1:0]  epoch_out;
    logic           busy_out;
    logic           done_out;
    logic           converged_out;

    modport master (
        output start_in, targets_in,
        input  w1_out, w2_out, wb_out, epoch_out, busy_out, done_out, converged_out
    );

    modport slave (
        input  start_in, targets_in,
        output w1_out, w2_out, wb_out, epoch_out, busy_out, done_out, converged_out
    );
endinterface

// File: rtl/perceptron_trainer.sv
// Sequential perceptron training engine for a 2-input fixed-point neuron.
// Walks the 4-entry binary truth table, applies w += LR*(t-y)*x per sample
// with saturating adds, and repeats epochs until an error-free epoch or the
// epoch limit. Weights are two's-complement sign+q_m+q_n words.
//
// state  | meaning
// IDLE   | waiting for start after reset
// EVAL   | compute neuron output and error for the current sample
// UPDATE | apply weight correction, advance sample index
// CHECK  | close the epoch: converge, give up, or start another epoch
// DONE   | results held until start or reset
module perceptron_trainer #(
    parameter int SIGN = 1,
    parameter int Q_M  = 16,
    parameter int Q_N  = 16,
    parameter int N    = SIGN + Q_M + Q_N,
    parameter logic [N-1:0] LR      = {{(N-1){1'b0}}, 1'b1} << Q_N,
    parameter logic [N-1:0] W1_INIT = '0,
    parameter logic [N-1:0] W2_INIT = '0,
    parameter logic [N-1:0] WB_INIT = '0,
    parameter int MAX_EPOCHS = 16,
    parameter int EW = $clog2(MAX_EPOCHS + 1)
) (
    input  logic clk,
    input  logic rst,
    perceptron_trainer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_UPDATE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   w1_q, w1_d;
    logic [N-1:0]   w2_q, w2_d;
    logic [N-1:0]   wb_q, wb_d;
    logic [EW-1:0]  epoch_q, epoch_d;
    logic [1:0]     idx_q, idx_d;
    logic           err_q, err_d;
    logic           conv_q, conv_d;
    logic [3:0]     tgt_q, tgt_d;
    logic [1:0]     e_q, e_d;      // signed error: 01 = +1, 00 = 0, 11 = -1

    logic           x1, x2;
    logic [N+1:0]   sum;
    logic           y;
    logic           t;

    // Adds +LR or -LR to a weight, clamping to the representable range.
    // LR is positive and narrower than the word, so one extra bit suffices.
    function automatic logic [N-1:0] sat_step(input logic [N-1:0] w, input logic neg);
        logic [N:0] a;
        logic [N:0] s;
        a = {w[N-1], w};
        s = neg ? (a - {1'b0, LR}) : (a + {1'b0, LR});
        if (s[N] != s[N-1]) begin
            return s[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
        return s[N-1:0];
    endfunction

    // Forward pass of the neuron for the current sample; N+2 bits cannot overflow.
    always_comb begin
        x1  = idx_q[1];
        x2  = idx_q[0];
        sum = {{2{wb_q[N-1]}}, wb_q}
            + (x1 ? {{2{w1_q[N-1]}}, w1_q} : '0)
            + (x2 ? {{2{w2_q[N-1]}}, w2_q} : '0);
        y   = !sum[N+1] && (sum != '0);
        t   = tgt_q[idx_q];
    end

    // Next-state and datapath updates for the training sequence.
    always_comb begin
        state_d = state_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        wb_d    = wb_q;
        epoch_d = epoch_q;
        idx_d   = idx_q;
        err_d   = err_q;
        conv_d  = conv_q;
        tgt_d   = tgt_q;
        e_d     = e_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start_in) begin
                    tgt_d   = bus.targets_in;
                    w1_d    = W1_INIT;
                    w2_d    = W2_INIT;
                    wb_d    = WB_INIT;
                    epoch_d = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    conv_d  = 1'b0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (t && !y) begin
                    e_d = 2'b01;
                end else if (!t && y) begin
                    e_d = 2'b11;
                end else begin
                    e_d = 2'b00;
                end
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (e_q != 2'b00) begin
                    wb_d  = sat_step(wb_q, e_q[1]);
                    if (x1) w1_d = sat_step(w1_q, e_q[1]);
                    if (x2) w2_d = sat_step(w2_q, e_q[1]);
                    err_d = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d = S_CHECK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_EVAL;
                end
            end
            S_CHECK: begin
                epoch_d = epoch_q + 1'b1;
                if (!err_q) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epoch_d == EW'(MAX_EPOCHS)) begin
                    conv_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_EVAL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset wins over any in-flight training.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            w1_q    <= W1_INIT;
            w2_q    <= W2_INIT;
            wb_q    <= WB_INIT;
            epoch_q <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            conv_q  <= 1'b0;
            tgt_q   <= '0;
            e_q     <= '0;
        end else begin
            state_q <= state_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            wb_q    <= wb_d;
            epoch_q <= epoch_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            conv_q  <= conv_d;
            tgt_q   <= tgt_d;
            e_q     <= e_d;
        end
    end

    assign bus.w1_out        = w1_q;
    assign bus.w2_out        = w2_q;
    assign bus.wb_out        = wb_q;
    assign bus.epoch_out     = epoch_q;
    assign bus.busy_out      = (state_q == S_EVAL) || (state_q == S_UPDATE) || (state_q == S_CHECK);
    assign bus.done_out      = (state_q == S_DONE);
    assign bus.converged_out = conv_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: directed truth-table cases plus random
// targets, checked against an integer-arithmetic perceptron model.
module tb_perceptron_trainer;

    localparam int N    = 33;
    localparam int EW   = 5;
    localparam int MAXE = 16;
    localparam logic [N-1:0] SAT_W1 = 33'h0_FFFF_FFFF;
    localparam logic [N-1:0] SAT_WB = 33'h1_0000_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    perceptron_trainer_if #(.N(N), .EW(EW)) bus ();
    perceptron_trainer_if #(.N(N), .EW(EW)) sbus ();

    perceptron_trainer #(.MAX_EPOCHS(MAXE)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    perceptron_trainer #(.MAX_EPOCHS(MAXE), .W1_INIT(SAT_W1), .WB_INIT(SAT_WB)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    longint tr_w1[$];
    longint tr_w2[$];
    longint tr_wb[$];

    function automatic longint to_l(input logic [N-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint clamp(input longint v);
        longint lo, hi;
        lo = -(longint'(1) << 32);
        hi = (longint'(1) << 32) - 1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    // Reference perceptron: plain integer arithmetic over the truth table.
    task automatic model_train(input logic [3:0] tg, input longint iw1, input longint iw2,
                               input longint iwb, input int maxep,
                               output longint ow1, output longint ow2, output longint owb,
                               output int oep, output bit oconv);
        longint w1, w2, wb, s, lr;
        int x1, x2, y, e;
        bit err;
        lr = 65536;
        w1 = iw1; w2 = iw2; wb = iwb;
        oep = 0; oconv = 0;
        tr_w1.delete(); tr_w2.delete(); tr_wb.delete();
        for (int ep = 1; ep <= maxep; ep++) begin
            err = 0;
            for (int smp = 0; smp < 4; smp++) begin
                x1 = smp / 2;
                x2 = smp % 2;
                s  = x1 * w1 + x2 * w2 + wb;
                y  = (s > 0) ? 1 : 0;
                e  = int'(tg[smp]) - y;
                if (e != 0) begin
                    err = 1;
                    wb = clamp(wb + e * lr);
                    if (x1 == 1) w1 = clamp(w1 + e * lr);
                    if (x2 == 1) w2 = clamp(w2 + e * lr);
                end
                tr_w1.push_back(w1);
                tr_w2.push_back(w2);
                tr_wb.push_back(wb);
            end
            oep = ep;
            if (!err) begin
                oconv = 1;
                break;
            end
        end
        ow1 = w1; ow2 = w2; owb = wb;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (bus.done_out === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [3:0] tg);
        @(negedge clk);
        bus.targets_in = tg;
        bus.start_in   = 1'b1;
        @(posedge clk); #1;
        bus.start_in   = 1'b0;
    endtask

    task automatic run_train(input logic [3:0] tg, output int lat);
        pulse_start(tg);
        wait_done(lat);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy_out); end
        n_checks++; if (bus.done_out !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done_out); end
        n_checks++; if (bus.converged_out !== 1'b0) begin n_fail++; $display("FAIL reset_conv got %0b want 0", bus.converged_out); end
        n_checks++; if (bus.epoch_out !== 5'd0) begin n_fail++; $display("FAIL reset_epoch got %0d want 0", bus.epoch_out); end
        n_checks++; if ({bus.w1_out, bus.w2_out, bus.wb_out} !== '0) begin n_fail++; $display("FAIL reset_weights got %h %h %h want 0", bus.w1_out, bus.w2_out, bus.wb_out); end
        n_checks++; if (sbus.w1_out !== SAT_W1 || sbus.wb_out !== SAT_WB) begin n_fail++; $display("FAIL reset_sat_init got %h %h want %h %h", sbus.w1_out, sbus.wb_out, SAT_W1, SAT_WB); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_and_result(input string tag, input int lat);
        n_checks++; if (lat !== 54) begin n_fail++; $display("FAIL %s_latency got %0d want 54", tag, lat); end
        n_checks++; if (bus.converged_out !== 1'b1) begin n_fail++; $display("FAIL %s_conv got %0b want 1", tag, bus.converged_out); end
        n_checks++; if (bus.epoch_out !== 5'd6) begin n_fail++; $display("FAIL %s_epoch got %0d want 6", tag, bus.epoch_out); end
        n_checks++; if (bus.w1_out !== 33'h0_0002_0000) begin n_fail++; $display("FAIL %s_w1 got %h want 000020000", tag, bus.w1_out); end
        n_checks++; if (bus.w2_out !== 33'h0_0001_0000) begin n_fail++; $display("FAIL %s_w2 got %h want 000010000", tag, bus.w2_out); end
        n_checks++; if (bus.wb_out !== 33'h1_FFFE_0000) begin n_fail++; $display("FAIL %s_wb got %h want 1fffe0000", tag, bus.wb_out); end
    endtask

    task automatic test_and;
        int lat;
        run_train(4'b1000, lat);
        check_and_result("and", lat);
    endtask

    task automatic test_zero;
        int lat;
        run_train(4'b0000, lat);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL zero_latency got %0d want 9", lat); end
        n_checks++; if (bus.converged_out !== 1'b1 || bus.epoch_out !== 5'd1) begin n_fail++; $display("FAIL zero_status got conv=%0b ep=%0d want conv=1 ep=1", bus.converged_out, bus.epoch_out); end
        n_checks++; if ({bus.w1_out, bus.w2_out, bus.wb_out} !== '0) begin n_fail++; $display("FAIL zero_weights got %h %h %h want 0", bus.w1_out, bus.w2_out, bus.wb_out); end
    endtask

    task automatic test_xor;
        int lat, ep;
        longint w1, w2, wb;
        bit conv;
        logic [N-1:0] e1, e2, eb;
        run_train(4'b0110, lat);
        model_train(4'b0110, 0, 0, 0, MAXE, w1, w2, wb, ep, conv);
        e1 = w1[N-1:0]; e2 = w2[N-1:0]; eb = wb[N-1:0];
        n_checks++; if (lat !== 144) begin n_fail++; $display("FAIL xor_latency got %0d want 144", lat); end
        n_checks++; if (bus.converged_out !== 1'b0 || bus.epoch_out !== 5'd16) begin n_fail++; $display("FAIL xor_status got conv=%0b ep=%0d want conv=0 ep=16", bus.converged_out, bus.epoch_out); end
        n_checks++; if (bus.w1_out !== e1 || bus.w2_out !== e2 || bus.wb_out !== eb) begin n_fail++; $display("FAIL xor_weights got %h %h %h want %h %h %h", bus.w1_out, bus.w2_out, bus.wb_out, e1, e2, eb); end
    endtask

    task automatic test_midstart;
        int lat1, lat2;
        pulse_start(4'b1000);
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.targets_in = 4'b0110;
        bus.start_in   = 1'b1;
        @(posedge clk); #1;
        bus.start_in   = 1'b0;
        lat1 = 12;
        wait_done(lat2);
        check_and_result("midstart", (lat2 < 0) ? -1 : lat1 + lat2);
    endtask

    task automatic test_done_restart;
        int lat;
        run_train(4'b1000, lat);
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (bus.done_out !== 1'b1 || bus.w1_out !== 33'h0_0002_0000 || bus.wb_out !== 33'h1_FFFE_0000) begin n_fail++; $display("FAIL done_hold got done=%0b w1=%h wb=%h want 1 000020000 1fffe0000", bus.done_out, bus.w1_out, bus.wb_out); end
        pulse_start(4'b1000);
        n_checks++; if ({bus.w1_out, bus.w2_out, bus.wb_out} !== '0 || bus.epoch_out !== 5'd0 || bus.busy_out !== 1'b1) begin n_fail++; $display("FAIL restart_reload got %h %h %h ep=%0d busy=%0b want 0 0 0 ep=0 busy=1", bus.w1_out, bus.w2_out, bus.wb_out, bus.epoch_out, bus.busy_out); end
        wait_done(lat);
        check_and_result("restart", lat);
    endtask

    task automatic test_reset_mid;
        int lat;
        pulse_start(4'b1000);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) begin n_fail++; $display("FAIL rstmid_status got busy=%0b done=%0b want 0 0", bus.busy_out, bus.done_out); end
        n_checks++; if ({bus.w1_out, bus.w2_out, bus.wb_out} !== '0 || bus.epoch_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_regs got %h %h %h ep=%0d want 0 0 0 ep=0", bus.w1_out, bus.w2_out, bus.wb_out, bus.epoch_out); end
        @(negedge clk);
        rst = 1'b0;
        run_train(4'b1000, lat);
        check_and_result("rstmid", lat);
    endtask

    task automatic test_saturation;
        longint w1, w2, wb;
        int ep;
        bit conv;
        logic [N-1:0] t1, tb;
        model_train(4'b0100, to_l(SAT_W1), 0, to_l(SAT_WB), MAXE, w1, w2, wb, ep, conv);
        t1 = tr_w1[2][N-1:0];
        tb = tr_wb[2][N-1:0];
        @(negedge clk);
        sbus.targets_in = 4'b0100;
        sbus.start_in   = 1'b1;
        @(posedge clk); #1;
        sbus.start_in   = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (sbus.w1_out !== 33'h0_FFFF_FFFF || sbus.w1_out !== t1) begin n_fail++; $display("FAIL sat_w1 got %h want 0ffffffff (model %h)", sbus.w1_out, t1); end
        n_checks++; if (sbus.wb_out !== 33'h1_0001_0001 || sbus.wb_out !== tb) begin n_fail++; $display("FAIL sat_wb got %h want 100010001 (model %h)", sbus.wb_out, tb); end
    endtask

    task automatic test_random;
        int lat, ep;
        longint w1, w2, wb;
        bit conv;
        logic [3:0] tg;
        logic [N-1:0] e1, e2, eb;
        for (int k = 0; k < 8; k++) begin
            tg = 4'($urandom_range(0, 15));
            run_train(tg, lat);
            model_train(tg, 0, 0, 0, MAXE, w1, w2, wb, ep, conv);
            e1 = w1[N-1:0]; e2 = w2[N-1:0]; eb = wb[N-1:0];
            n_checks++; if (lat !== 9 * ep) begin n_fail++; $display("FAIL rand_latency tg=%b got %0d want %0d", tg, lat, 9 * ep); end
            n_checks++; if (bus.epoch_out !== EW'(ep) || bus.converged_out !== conv) begin n_fail++; $display("FAIL rand_status tg=%b got ep=%0d conv=%0b want ep=%0d conv=%0b", tg, bus.epoch_out, bus.converged_out, ep, conv); end
            n_checks++; if (bus.w1_out !== e1 || bus.w2_out !== e2 || bus.wb_out !== eb) begin n_fail++; $display("FAIL rand_weights tg=%b got %h %h %h want %h %h %h", tg, bus.w1_out, bus.w2_out, bus.wb_out, e1, e2, eb); end
        end
    endtask

    initial begin
        bus.start_in    = 1'b0;
        bus.targets_in  = 4'b0000;
        sbus.start_in   = 1'b0;
        sbus.targets_in = 4'b0000;
        rst = 1'b1;
        test_reset;
        test_and;
        test_zero;
        test_xor;
        test_midstart;
        test_done_restart;
        test_reset_mid;
        test_saturation;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
